// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand-steering modes and
// the helper that sizes channel-index fields.
package calc_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int unsigned chan_idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer, and advances the pointer past the granted channel on request.
module rr_arbiter
   import calc_pkg::*;
#(
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SEL_W    = chan_idx_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] req,
   input  logic                advance,
   output logic [CHANNELS-1:0] grant,
   output logic [SEL_W-1:0]    grant_idx
);

   localparam logic [SEL_W:0]   CH_CNT  = (SEL_W + 1)'(CHANNELS);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W:0]   w_sum;
   logic [SEL_W-1:0] w_idx;
   logic             w_found;

   // One extra bit on the sum so the wrap works for non-power-of-two counts.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int unsigned off = 0; off < CHANNELS; off++) begin
         w_sum = {1'b0, r_ptr} + (SEL_W + 1)'(off);
         if (w_sum >= CH_CNT) begin
            w_sum = w_sum - CH_CNT;
         end
         w_idx = w_sum[SEL_W-1:0];
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
            w_found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/operand_mux_arb.sv
// N-channel operand selector with fixed or round-robin selection feeding a
// single-entry registered valid/ready output stage.
module operand_mux_arb
   import calc_pkg::*;
#(
   parameter  int unsigned WIDTH    = 4,
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SEL_W    = chan_idx_w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_chan;

   logic                w_rr_mode;
   logic                w_load_en;
   logic                w_xfer;
   logic [CHANNELS-1:0] w_req;
   logic [CHANNELS-1:0] w_fix_grant;
   logic [CHANNELS-1:0] w_rr_grant;
   logic [CHANNELS-1:0] w_grant;
   logic [SEL_W-1:0]    w_rr_idx;
   logic [SEL_W-1:0]    w_idx;
   logic [WIDTH-1:0]    w_data;

   assign w_rr_mode = (mode == MODE_RR);
   assign w_load_en = !r_out_valid || out_ready;
   // Gating requests with reset keeps in_ready low while reset is held.
   assign w_req     = in_valid & {CHANNELS{!rst}};

   // An out-of-range select matches no channel and so grants nothing.
   always_comb begin
      w_fix_grant = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) begin
            w_fix_grant[i] = w_req[i];
         end
      end
   end

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (w_req),
      .advance   (w_xfer && w_rr_mode),
      .grant     (w_rr_grant),
      .grant_idx (w_rr_idx)
   );

   assign w_grant  = w_rr_mode ? w_rr_grant : w_fix_grant;
   assign w_idx    = w_rr_mode ? w_rr_idx : sel;
   assign w_xfer   = (|w_grant) && w_load_en;
   assign in_ready = w_grant & {CHANNELS{w_load_en}};

   always_comb begin
      w_data = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_data = w_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_chan  <= w_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;

endmodule
